// File: rtl/ajuste_escala.sv
// ajuste_escala: two-stage pipelined fixed-point rescaler.
// Picks an OUT_W window at a run-time shift, with rounding and saturation.
module ajuste_escala #(
    parameter int IN_W    = 60,
    parameter int OUT_W   = 18,
    parameter int SHIFT_W = 6,
    parameter int SIGNED  = 0,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    r,
    input  logic [SHIFT_W-1:0] s,
    input  logic               rnd,
    input  logic               sat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   y,
    output logic               ovf,
    output logic               err,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   ovf_cnt
);

    localparam int MAX_S = IN_W - OUT_W;
    localparam logic [OUT_W-1:0] U_MAX = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic adv1;
    logic adv2;

    logic             v1;
    logic [OUT_W-1:0] win1;
    logic             rb1;
    logic             hi1;
    logic             neg1;
    logic             rnd1;
    logic             sat1;
    logic             err1;

    logic [IN_W:0]    rr;
    logic [IN_W:0]    rs;
    logic             hi_c;

    logic             inc;
    logic [OUT_W:0]   sum;
    logic             carry;
    logic             ovf_c;
    logic [OUT_W-1:0] y_c;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    // A guard bit below r turns the round bit into rs[0] for every shift.
    always_comb begin
        rr   = {r, 1'b0};
        rs   = '0;
        hi_c = 1'b0;
        if (SIGNED != 0) begin
            rs   = $signed(rr) >>> s;
            hi_c = !((&rs[IN_W:OUT_W]) || !(|rs[IN_W:OUT_W]));
        end else begin
            rs   = rr >> s;
            hi_c = |rs[IN_W:OUT_W+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            win1 <= '0;
            rb1  <= 1'b0;
            hi1  <= 1'b0;
            neg1 <= 1'b0;
            rnd1 <= 1'b0;
            sat1 <= 1'b0;
            err1 <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                win1 <= rs[OUT_W:1];
                rb1  <= rs[0];
                hi1  <= hi_c;
                neg1 <= r[IN_W-1];
                rnd1 <= rnd;
                sat1 <= sat;
                err1 <= (s > SHIFT_W'(MAX_S));
            end
        end
    end

    always_comb begin
        inc   = rnd1 & rb1;
        sum   = {1'b0, win1} + {{OUT_W{1'b0}}, inc};
        carry = 1'b0;
        y_c   = sum[OUT_W-1:0];
        if (SIGNED != 0) begin
            carry = (win1 == S_MAX) && inc;
        end else begin
            carry = sum[OUT_W];
        end
        ovf_c = hi1 | carry;
        if (err1) begin
            y_c   = '0;
            ovf_c = 1'b0;
        end else if (ovf_c && sat1) begin
            if (SIGNED != 0) begin
                y_c = neg1 ? S_MIN : S_MAX;
            end else begin
                y_c = U_MAX;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else if (adv2) begin
            out_valid <= v1;
            if (v1) begin
                y   <= y_c;
                ovf <= ovf_c;
                err <= err1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (clr_cnt) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && ovf && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ajuste_escala.sv
// tb_ajuste_escala: unsigned and signed instances driven side by side,
// checked against an arithmetic reference model and a vector table.
module tb_ajuste_escala;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        rnd = 1'b0;
    logic        sat = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [59:0] r = '0;
    logic [5:0]  s = '0;

    logic        rdy_u, vu, ov_u, er_u;
    logic [17:0] y_u;
    logic [15:0] cnt_u;
    logic        rdy_s, vs, ov_s, er_s;
    logic [17:0] y_s;
    logic [2:0]  cnt_s;

    int nvec = 0;
    int nbad = 0;
    int cnt_eu = 0;
    int cnt_es = 0;
    int n_out = 0;
    bit mon_on = 0;

    typedef struct packed {
        logic [59:0] r;
        logic [5:0]  s;
        logic        rnd;
        logic        sat;
    } in_t;

    typedef struct {
        logic [59:0] r;
        int          s;
        bit          rnd;
        bit          sat;
        bit          sgn;
        logic [17:0] y;
        bit          ovf;
        bit          err;
    } vec_t;

    in_t  q[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    ajuste_escala #(
        .IN_W(60), .OUT_W(18), .SHIFT_W(6), .SIGNED(0), .CNT_W(16)
    ) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
        .r(r), .s(s), .rnd(rnd), .sat(sat), .out_valid(vu),
        .out_ready(out_ready), .y(y_u), .ovf(ov_u), .err(er_u),
        .clr_cnt(clr_cnt), .ovf_cnt(cnt_u)
    );

    ajuste_escala #(
        .IN_W(60), .OUT_W(18), .SHIFT_W(6), .SIGNED(1), .CNT_W(3)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .r(r), .s(s), .rnd(rnd), .sat(sat), .out_valid(vs),
        .out_ready(out_ready), .y(y_s), .ovf(ov_s), .err(er_s),
        .clr_cnt(clr_cnt), .ovf_cnt(cnt_s)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: floor(r / 2^s), optional half-up increment, range test.
    function automatic logic [19:0] model(input logic [59:0] rv,
                                          input int sv, input bit rn,
                                          input bit st, input bit sg);
        longint v, qv, rem, lo, hi;
        logic [17:0] yv;
        bit o;
        if (sv > 42) return {18'd0, 1'b0, 1'b1};
        if (sg) v = longint'($signed(rv));
        else v = longint'({4'd0, rv});
        qv  = v >>> sv;
        rem = v - (qv <<< sv);
        if (rn && sv > 0 && rem >= (longint'(1) <<< (sv - 1))) qv = qv + 1;
        lo = sg ? -(longint'(1) <<< 17) : longint'(0);
        hi = sg ? (longint'(1) <<< 17) - 1 : (longint'(1) <<< 18) - 1;
        o  = (qv < lo) || (qv > hi);
        yv = qv[17:0];
        if (o && st) yv = !sg ? 18'h3FFFF : (v < 0 ? 18'h20000 : 18'h1FFFF);
        return {yv, o, 1'b0};
    endfunction

    task automatic bump(input bit ou, input bit os);
        if (ou && cnt_eu < 65535) cnt_eu++;
        if (os && cnt_es < 7) cnt_es++;
    endtask

    task automatic run_vec(input vec_t t, input string nm);
        logic [19:0] mu, ms;
        int cyc;
        r = t.r; s = 6'(t.s); rnd = t.rnd; sat = t.sat; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!vu && cyc < 6) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "_lat"}, 64'(cyc), 64'd2);
        mu = model(t.r, t.s, t.rnd, t.sat, 1'b0);
        ms = model(t.r, t.s, t.rnd, t.sat, 1'b1);
        check({nm, "_mu"}, {y_u, ov_u, er_u}, mu);
        check({nm, "_ms"}, {y_s, ov_s, er_s}, ms);
        if (t.sgn) check({nm, "_tbl"}, {y_s, ov_s, er_s}, {t.y, t.ovf, t.err});
        else check({nm, "_tbl"}, {y_u, ov_u, er_u}, {t.y, t.ovf, t.err});
        bump(mu[1], ms[1]);
    endtask

    // Scoreboard monitor: transfers are judged half a cycle before the edge.
    initial begin
        in_t e;
        logic [19:0] pu, ps, mu, ms;
        bit stall;
        stall = 0;
        pu = '0; ps = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_on) begin
                stall = 0;
            end else begin
                if (stall) begin
                    check("hold_u", {y_u, ov_u, er_u}, pu);
                    check("hold_s", {y_s, ov_s, er_s}, ps);
                end
                check("valid_pair", vs, vu);
                if (vu && out_ready) begin
                    if (q.size() == 0) begin
                        check("spurious_out", 1, 0);
                    end else begin
                        e  = q.pop_front();
                        mu = model(e.r, int'(e.s), e.rnd, e.sat, 1'b0);
                        ms = model(e.r, int'(e.s), e.rnd, e.sat, 1'b1);
                        check("stream_u", {y_u, ov_u, er_u}, mu);
                        check("stream_s", {y_s, ov_s, er_s}, ms);
                        bump(mu[1], ms[1]);
                        n_out++;
                    end
                end
                if (in_valid && rdy_u) q.push_back({r, s, rnd, sat});
                stall = vu && !out_ready;
                pu = {y_u, ov_u, er_u};
                ps = {y_s, ov_s, er_s};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic [59:0] w[6];
        logic [63:0] t;
        bit acc, seen;
        int idx, cyc, k;

        tbl[0]  = '{60'h18, 4, 0, 0, 0, 18'h00001, 0, 0};
        tbl[1]  = '{60'h18, 4, 1, 0, 0, 18'h00002, 0, 0};
        tbl[2]  = '{60'h40000, 0, 0, 1, 0, 18'h3FFFF, 1, 0};
        tbl[3]  = '{60'h40000, 0, 0, 0, 0, 18'h00000, 1, 0};
        tbl[4]  = '{60'h7FFFF, 1, 1, 1, 0, 18'h3FFFF, 1, 0};
        tbl[5]  = '{60'hFFFFFFFFFFFFFFF, 42, 0, 0, 1, 18'h3FFFF, 0, 0};
        tbl[6]  = '{60'h100000000, 0, 0, 1, 1, 18'h1FFFF, 1, 0};
        tbl[7]  = '{60'hFFFFF0000000000, 0, 0, 1, 1, 18'h20000, 1, 0};
        tbl[8]  = '{60'h12345, 43, 1, 1, 0, 18'h00000, 0, 1};
        tbl[9]  = '{60'h123, 43, 0, 0, 1, 18'h00000, 0, 1};
        tbl[10] = '{60'hFFFFFFFFFFFFFFF, 42, 0, 0, 0, 18'h3FFFF, 0, 0};
        tbl[11] = '{60'h3FFFF, 1, 1, 1, 1, 18'h1FFFF, 1, 0};
        tbl[12] = '{60'h3FFFF, 1, 1, 0, 1, 18'h20000, 1, 0};

        #12;
        check("rst_valid", {vu, vs}, 2'b00);
        check("rst_y", {y_u, y_s}, 36'd0);
        check("rst_flags", {ov_u, er_u, ov_s, er_s}, 4'd0);
        check("rst_cnt", {cnt_u, cnt_s}, 19'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", {rdy_u, rdy_s}, 2'b11);

        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("v%0d", i));
        @(posedge clk); #1;
        check("cnt_u_tbl", cnt_u, 64'(cnt_eu));
        check("cnt_s_sat", cnt_s, 64'(cnt_es));

        run_vec('{60'h40000, 0, 0, 1, 0, 18'h3FFFF, 1, 0}, "clr");
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        check("clr_prio", {cnt_u, cnt_s}, 19'd0);
        cnt_eu = 0;
        cnt_es = 0;

        mon_on = 1;
        for (int i = 0; i < 6; i++) w[i] = 60'(i * 37 + 16) << (i * 3);
        out_ready = 1'b0;
        idx = 0;
        cyc = 0;
        r = w[0]; s = 6'd3; rnd = 1'b1; sat = 1'b0; in_valid = 1'b1;
        while (idx < 6 && cyc < 60) begin
            @(negedge clk);
            acc = rdy_u;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
            if (cyc == 5) begin
                check("bp_accepted", 64'(idx), 64'd2);
                check("bp_ready", {rdy_u, rdy_s}, 2'b00);
                check("bp_outv", vu, 1'b1);
                out_ready = 1'b1;
            end
            if (idx < 6) r = w[idx];
            else in_valid = 1'b0;
        end
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_drain", 64'(q.size()), 64'd0);
        check("bp_count", 64'(n_out), 64'd6);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            t = {$urandom, $urandom};
            r = t[59:0] >> $urandom_range(0, 59);
            if ($urandom % 2) r = -r;
            s   = 6'($urandom_range(0, 47));
            rnd = 1'($urandom);
            sat = 1'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("rnd_drain", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
        check("cnt_u_rnd", cnt_u, 64'(cnt_eu));
        check("cnt_s_rnd", cnt_s, 64'(cnt_es));

        out_ready = 1'b0;
        r = 60'h5000; s = 6'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {vu, vs}, 2'b00);
        check("mid_rst_cnt", {cnt_u, cnt_s}, 19'd0);
        q.delete();
        cnt_eu = 0;
        cnt_es = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | vu | vs;
        end
        check("mid_rst_quiet", seen, 1'b0);
        check("mid_rst_ready", {rdy_u, rdy_s}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
